// File: rtl/serdiv_req_sc.sv
`default_nettype none
// ============================================================================
// Module      : serdiv_req_sc
// Description : Requester/consumer for the label-aware serial divider: issues
//               one div/rem op, collects the labelled result into a 1-entry
//               writeback buffer and flags handshake protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module serdiv_req_sc #(
    parameter int WIDTH = 64,
    parameter int IDW   = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             fu_valid_i,
    output logic             fu_ready_o,
    input  logic [IDW-1:0]   fu_id_i,
    input  logic [WIDTH-1:0] fu_op_a_i,
    input  logic [WIDTH-1:0] fu_op_b_i,
    input  logic [1:0]       fu_opcode_i,
    input  logic             fu_a_label_i,
    input  logic             fu_b_label_i,
    input  logic             div_in_rdy_i,
    output logic             div_in_vld_o,
    output logic [IDW-1:0]   div_id_o,
    output logic [WIDTH-1:0] div_op_a_o,
    output logic [WIDTH-1:0] div_op_b_o,
    output logic [1:0]       div_opcode_o,
    output logic             div_a_label_o,
    output logic             div_b_label_o,
    output logic             div_flush_o,
    input  logic             div_out_vld_i,
    output logic             div_out_rdy_o,
    input  logic [IDW-1:0]   div_id_i,
    input  logic [WIDTH-1:0] div_res_i,
    input  logic             div_label_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [IDW-1:0]   wb_id_o,
    output logic [WIDTH-1:0] wb_result_o,
    output logic             wb_label_o,
    output logic             err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_fu_ready;
    logic             w_in_vld;
    logic             w_out_rdy;
    logic             w_accept;
    logic             w_load;
    logic             w_spurious;
    logic             w_id_mismatch;

    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [1:0]       r_opcode;
    logic             r_a_label;
    logic             r_b_label;

    logic             r_wb_valid;
    logic [IDW-1:0]   r_wb_id;
    logic [WIDTH-1:0] r_wb_result;
    logic             r_wb_label;
    logic             r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
                S_ISSUE: w_state_nxt = S_BUSY;
                S_BUSY:  if (w_load) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Flush masks every handshake strobe so nothing is accepted or loaded in that cycle.
    always_comb begin
        w_fu_ready = 1'b0;
        w_in_vld   = 1'b0;
        w_out_rdy  = 1'b0;
        case (r_state)
            S_IDLE:  w_fu_ready = div_in_rdy_i & ~r_wb_valid & ~flush_i;
            S_ISSUE: w_in_vld   = ~flush_i;
            S_BUSY:  w_out_rdy  = (~r_wb_valid | wb_ready_i) & ~flush_i;
            default: w_fu_ready = 1'b0;
        endcase
    end

    assign w_accept      = fu_valid_i & w_fu_ready;
    assign w_load        = div_out_vld_i & w_out_rdy;
    assign w_spurious    = div_out_vld_i & (r_state != S_BUSY);
    assign w_id_mismatch = w_load & (div_id_i != r_id);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id      <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_opcode  <= '0;
            r_a_label <= 1'b0;
            r_b_label <= 1'b0;
        end else if (w_accept) begin
            r_id      <= fu_id_i;
            r_op_a    <= fu_op_a_i;
            r_op_b    <= fu_op_b_i;
            r_opcode  <= fu_opcode_i;
            r_a_label <= fu_a_label_i;
            r_b_label <= fu_b_label_i;
        end
    end

    // A load in the same cycle as a drain keeps the buffer valid with the new entry.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wb_valid  <= 1'b0;
            r_wb_id     <= '0;
            r_wb_result <= '0;
            r_wb_label  <= 1'b0;
        end else if (flush_i) begin
            r_wb_valid  <= 1'b0;
        end else if (w_load) begin
            r_wb_valid  <= 1'b1;
            r_wb_id     <= div_id_i;
            r_wb_result <= div_res_i;
            r_wb_label  <= div_label_i;
        end else if (wb_ready_i) begin
            r_wb_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_spurious | w_id_mismatch) begin
            r_err <= 1'b1;
        end
    end

    assign fu_ready_o    = w_fu_ready;
    assign div_in_vld_o  = w_in_vld;
    assign div_out_rdy_o = w_out_rdy;
    assign div_flush_o   = flush_i;
    assign div_id_o      = r_id;
    assign div_op_a_o    = r_op_a;
    assign div_op_b_o    = r_op_b;
    assign div_opcode_o  = r_opcode;
    assign div_a_label_o = r_a_label;
    assign div_b_label_o = r_b_label;
    assign wb_valid_o    = r_wb_valid;
    assign wb_id_o       = r_wb_id;
    assign wb_result_o   = r_wb_result;
    assign wb_label_o    = r_wb_label;
    assign err_o         = r_err;

endmodule
`default_nettype wire
